// File: rtl/fir_pkg.sv
// fir_pkg
// Shared parameters and types for the distributed-arithmetic table builder.
// Holds the table geometry (64 taps in 8 groups of 8, 2048 entries), the
// coefficient/entry widths, and the builder FSM state encoding.
package fir_pkg;
   localparam int NTAPS     = 64;
   localparam int GRP       = 8;
   localparam int NGROUPS   = NTAPS / GRP;
   localparam int LUT_DEPTH = NGROUPS * (2 ** GRP);
   localparam int COEF_W    = 16;
   localparam int LUT_W     = COEF_W + $clog2(GRP);
   localparam int ADDR_W    = $clog2(LUT_DEPTH);
   localparam int CNT_W     = $clog2(NTAPS);
   localparam int GRP_W     = $clog2(GRP);
   localparam int NGRP_W    = $clog2(NGROUPS);

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [LUT_W-1:0]  lut_t;
   typedef logic [ADDR_W-1:0]        addr_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_BUILD   = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;
endpackage

// File: rtl/fir_lut_builder_if.sv
// fir_lut_builder_if
// Bundles the coefficient stream (coef_in/coef_valid/coef_ready), the
// filter coefficient-load port (CIN/CADDR/CLOAD) and the busy/done status.
// slave  : the builder side (consumes coefficients, drives the table).
// master : the coefficient source / table consumer side.
interface fir_lut_builder_if;
   import fir_pkg::*;

   coef_t coef_in;
   logic  coef_valid;
   logic  coef_ready;
   lut_t  CIN;
   addr_t CADDR;
   logic  CLOAD;
   logic  busy;
   logic  done;

   modport slave (
      input  coef_in, coef_valid,
      output coef_ready, CIN, CADDR, CLOAD, busy, done
   );

   modport master (
      output coef_in, coef_valid,
      input  coef_ready, CIN, CADDR, CLOAD, busy, done
   );
endinterface

// File: rtl/da_adder_tree.sv
// da_adder_tree
// Three registered stages that turn 8 coefficients plus a bit mask into
// their masked signed sum: S1 selects terms, S2 forms 4 pair sums, S3 forms
// 2 quad sums. The final quad+quad add is left combinational so the caller's
// output register absorbs it. Valid and address ride alongside the data.
// Ports: clk_slow/reset, terms (8 x COEF_W), mask, in_valid, in_addr ->
//        sum (LUT_W), out_valid, out_addr.
module da_adder_tree
   import fir_pkg::*;
(
   input  logic                       clk_slow,
   input  logic                       reset,
   input  logic [GRP-1:0][COEF_W-1:0] terms,
   input  logic [GRP-1:0]             mask,
   input  logic                       in_valid,
   input  addr_t                      in_addr,
   output lut_t                       sum,
   output logic                       out_valid,
   output addr_t                      out_addr
);
   logic signed [COEF_W-1:0] s1 [GRP];
   logic signed [COEF_W:0]   s2 [GRP/2];
   logic signed [COEF_W+1:0] s3 [GRP/4];
   logic [2:0]               vld;
   addr_t                    adr [3];

   always_ff @(posedge clk_slow) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld <= {vld[1:0], in_valid};
      end
   end

   // Data path carries no reset; only the valid chain needs clearing.
   always_ff @(posedge clk_slow) begin
      for (int i = 0; i < GRP; i++) begin
         s1[i] <= mask[i] ? terms[i] : '0;
      end
      for (int j = 0; j < GRP/2; j++) begin
         s2[j] <= {s1[2*j][COEF_W-1], s1[2*j]} + {s1[2*j+1][COEF_W-1], s1[2*j+1]};
      end
      for (int j = 0; j < GRP/4; j++) begin
         s3[j] <= {s2[2*j][COEF_W], s2[2*j]} + {s2[2*j+1][COEF_W], s2[2*j+1]};
      end
      adr[0] <= in_addr;
      adr[1] <= adr[0];
      adr[2] <= adr[1];
   end

   assign sum       = {s3[0][COEF_W+1], s3[0]} + {s3[1][COEF_W+1], s3[1]};
   assign out_valid = vld[2];
   assign out_addr  = adr[2];
endmodule

// File: rtl/fir_lut_builder.sv
// fir_lut_builder
// Collects 64 signed coefficients over a valid/ready stream, then streams
// the 2048-entry DA partial-sum table (8 groups x 256 masks) into the
// filter's coefficient-load port, one entry per clock.
// Ports: clk_slow (sole clock), reset (sync, active-high),
//        lut_bus (slave): coef_in/coef_valid/coef_ready in,
//        CIN/CADDR/CLOAD/busy/done out.
//
// state   | meaning
// IDLE    | waiting for first coefficient, count = 0
// COLLECT | accepting coefficients until 64 are stored
// BUILD   | issuing table addresses 0..2047, one per clock
// DRAIN   | waiting for the last entry to leave the pipeline
// DONE    | one-cycle completion pulse, then IDLE
module fir_lut_builder
   import fir_pkg::*;
(
   input  logic             clk_slow,
   input  logic             reset,
   fir_lut_builder_if.slave lut_bus
);
   state_t                     state, state_nxt;
   coef_t                      coef_mem [NTAPS];
   logic [CNT_W-1:0]           cnt;
   addr_t                      a;
   logic                       accept, issue;
   logic                       coef_ready_q, busy_q, done_q, cload_q;
   addr_t                      caddr_q;
   lut_t                       cin_q;
   logic [GRP-1:0][COEF_W-1:0] terms;
   lut_t                       tree_sum;
   logic                       tree_valid;
   addr_t                      tree_addr;

   // Group k = a[10:8] selects coefficients 8k..8k+7.
   always_comb begin
      for (int b = 0; b < GRP; b++) begin
         terms[b] = coef_mem[{a[ADDR_W-1 -: NGRP_W], GRP_W'(b)}];
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = lut_bus.coef_valid && coef_ready_q;
      issue     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (accept && (cnt == CNT_W'(NTAPS - 1))) state_nxt = ST_BUILD;
         end
         ST_BUILD: begin
            issue = 1'b1;
            if (a == addr_t'(LUT_DEPTH - 1)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cload_q && (caddr_q == addr_t'(LUT_DEPTH - 1))) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk_slow) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         a            <= '0;
         coef_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         if (accept) cnt <= cnt + CNT_W'(1);
         if (issue)  a   <= a + ADDR_W'(1);
         coef_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_COLLECT);
         busy_q       <= (state_nxt == ST_COLLECT) || (state_nxt == ST_BUILD) ||
                         (state_nxt == ST_DRAIN);
         done_q       <= (state_nxt == ST_DONE);
      end
   end

   // Coefficient store keeps its contents across loads; a reset cycle never writes.
   always_ff @(posedge clk_slow) begin
      if (!reset && accept) coef_mem[cnt] <= lut_bus.coef_in;
   end

   da_adder_tree u_tree (
      .clk_slow  (clk_slow),
      .reset     (reset),
      .terms     (terms),
      .mask      (a[GRP-1:0]),
      .in_valid  (issue),
      .in_addr   (a),
      .sum       (tree_sum),
      .out_valid (tree_valid),
      .out_addr  (tree_addr)
   );

   always_ff @(posedge clk_slow) begin
      if (reset) begin
         cload_q <= 1'b0;
         caddr_q <= '0;
         cin_q   <= '0;
      end else begin
         cload_q <= tree_valid;
         if (tree_valid) begin
            caddr_q <= tree_addr;
            cin_q   <= tree_sum;
         end
      end
   end

   assign lut_bus.coef_ready = coef_ready_q;
   assign lut_bus.busy       = busy_q;
   assign lut_bus.done       = done_q;
   assign lut_bus.CLOAD      = cload_q;
   assign lut_bus.CADDR      = caddr_q;
   assign lut_bus.CIN        = cin_q;
endmodule
